// File: rtl/riscv_perf_window_monitor.sv
// Windowed core performance monitor: accumulates retire/L1/stall events over a fixed window,
// then derives IPC, L1 hit rate and stall percentage with one shared restoring divider.
module riscv_perf_window_monitor #(
    parameter int unsigned WINDOW_CYCLES            = 1024,
    parameter int unsigned COUNTER_WIDTH            = 32,
    parameter int unsigned IPC_PRECISION            = 1000,
    parameter int unsigned IPC_TARGET               = 85,
    parameter int unsigned CACHE_MISS_THRESHOLD     = 15,
    parameter int unsigned PIPELINE_STALL_THRESHOLD = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic [1:0]  retire_cnt_i,
    input  logic        l1_hit_i,
    input  logic        l1_miss_i,
    input  logic        stall_i,
    output logic [15:0] ipc_o,
    output logic [15:0] l1_hit_rate_o,
    output logic [7:0]  stall_pct_o,
    output logic        results_valid_o,
    output logic        ipc_low_o,
    output logic        cache_miss_high_o,
    output logic        stall_high_o,
    output logic        busy_o
);

    localparam int unsigned Dw          = COUNTER_WIDTH + $clog2(IPC_PRECISION + 1);
    localparam int unsigned CycW        = $clog2(WINDOW_CYCLES);
    localparam int unsigned BitW        = $clog2(Dw);
    localparam int unsigned IpcLowLimit = IPC_TARGET * IPC_PRECISION / 100;
    localparam int unsigned HitLowLimit =
        IPC_PRECISION - CACHE_MISS_THRESHOLD * IPC_PRECISION / 100;
    localparam logic [CycW-1:0] LastCyc   = CycW'(WINDOW_CYCLES - 1);
    localparam logic [Dw-1:0]   WindowDiv = Dw'(WINDOW_CYCLES);

    // The divide must finish before the next window can possibly close.
    if (WINDOW_CYCLES < 3 * Dw + 4) begin : g_window_too_short
        $error("WINDOW_CYCLES must be at least 3*DW+4");
    end

    function automatic logic [COUNTER_WIDTH-1:0] sat_add(input logic [COUNTER_WIDTH-1:0] a,
                                                         input logic [1:0] b);
        logic [COUNTER_WIDTH:0] s;
        s = {1'b0, a} + {{(COUNTER_WIDTH - 1){1'b0}}, b};
        return s[COUNTER_WIDTH] ? '1 : s[COUNTER_WIDTH-1:0];
    endfunction

    function automatic logic [15:0] sat16(input logic [Dw-1:0] q);
        return (|q[Dw-1:16]) ? 16'hFFFF : q[15:0];
    endfunction

    function automatic logic [7:0] sat8(input logic [Dw-1:0] q);
        return (|q[Dw-1:8]) ? 8'hFF : q[7:0];
    endfunction

    typedef enum logic {StIdle, StCount} cnt_state_e;
    typedef enum logic [2:0] {DIdle, DIpc, DHit, DStall, DLoad} div_state_e;

    cnt_state_e               cnt_state_q;
    logic [CycW-1:0]          cyc_q;
    logic [COUNTER_WIDTH-1:0] ret_q, hit_q, miss_q, stall_q;
    logic [COUNTER_WIDTH-1:0] ret_sum, hit_sum, miss_sum, stall_sum;
    logic [COUNTER_WIDTH-1:0] hit_snap_q, miss_snap_q, stall_snap_q;
    logic                     counting, in_count, win_close, hits_zero;

    div_state_e      div_state_q;
    logic [Dw-1:0]   rem_q, quo_q, div_q;
    logic [BitW-1:0] bit_q;
    logic [Dw:0]     shifted;
    logic            div_ge, last_bit;
    logic [Dw-1:0]   rem_next, quo_next;
    logic [Dw-1:0]   ipc_dividend, hit_dividend, hit_divisor, stall_dividend;
    logic [15:0]     ipc_res_q, hit_res_q;
    logic [7:0]      stall_res_q;

    always_comb begin
        counting  = enable_i && !clear_i;
        in_count  = (cnt_state_q == StCount);
        win_close = counting && (cyc_q == LastCyc);
        ret_sum   = sat_add(in_count ? ret_q : '0, retire_cnt_i);
        hit_sum   = sat_add(in_count ? hit_q : '0, {1'b0, l1_hit_i});
        miss_sum  = sat_add(in_count ? miss_q : '0, {1'b0, l1_miss_i});
        stall_sum = sat_add(in_count ? stall_q : '0, {1'b0, stall_i});
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_state_q  <= StIdle;
            cyc_q        <= '0;
            ret_q        <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            stall_q      <= '0;
            hit_snap_q   <= '0;
            miss_snap_q  <= '0;
            stall_snap_q <= '0;
        end else if (!counting) begin
            cnt_state_q <= StIdle;
            cyc_q       <= '0;
            ret_q       <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            stall_q     <= '0;
        end else begin
            cnt_state_q <= StCount;
            if (win_close) begin
                hit_snap_q   <= hit_sum;
                miss_snap_q  <= miss_sum;
                stall_snap_q <= stall_sum;
                cyc_q        <= '0;
                ret_q        <= '0;
                hit_q        <= '0;
                miss_q       <= '0;
                stall_q      <= '0;
            end else begin
                cyc_q   <= cyc_q + 1'b1;
                ret_q   <= ret_sum;
                hit_q   <= hit_sum;
                miss_q  <= miss_sum;
                stall_q <= stall_sum;
            end
        end
    end

    // With no L1 traffic the hit pass divides P by 1, giving the defined 100% result.
    always_comb begin
        hits_zero      = (hit_snap_q == '0) && (miss_snap_q == '0);
        ipc_dividend   = Dw'(ret_sum) * Dw'(IPC_PRECISION);
        hit_dividend   = hits_zero ? Dw'(IPC_PRECISION) : Dw'(hit_snap_q) * Dw'(IPC_PRECISION);
        hit_divisor    = hits_zero ? Dw'(1) : Dw'(hit_snap_q) + Dw'(miss_snap_q);
        stall_dividend = Dw'(stall_snap_q) * Dw'(100);
        shifted        = {rem_q, quo_q[Dw-1]};
        div_ge         = shifted >= {1'b0, div_q};
        rem_next       = div_ge ? (shifted[Dw-1:0] - div_q) : shifted[Dw-1:0];
        quo_next       = {quo_q[Dw-2:0], div_ge};
        last_bit       = (bit_q == BitW'(Dw - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_state_q       <= DIdle;
            rem_q             <= '0;
            quo_q             <= '0;
            div_q             <= '0;
            bit_q             <= '0;
            ipc_res_q         <= '0;
            hit_res_q         <= '0;
            stall_res_q       <= '0;
            ipc_o             <= '0;
            l1_hit_rate_o     <= '0;
            stall_pct_o       <= '0;
            results_valid_o   <= 1'b0;
            ipc_low_o         <= 1'b0;
            cache_miss_high_o <= 1'b0;
            stall_high_o      <= 1'b0;
        end else begin
            results_valid_o <= 1'b0;
            unique case (div_state_q)
                DIdle: begin
                    if (win_close) begin
                        rem_q       <= '0;
                        quo_q       <= ipc_dividend;
                        div_q       <= WindowDiv;
                        bit_q       <= '0;
                        div_state_q <= DIpc;
                    end
                end
                DIpc, DHit, DStall: begin
                    rem_q <= last_bit ? '0 : rem_next;
                    bit_q <= last_bit ? '0 : bit_q + 1'b1;
                    quo_q <= quo_next;
                    if (last_bit) begin
                        if (div_state_q == DIpc) begin
                            ipc_res_q   <= sat16(quo_next);
                            quo_q       <= hit_dividend;
                            div_q       <= hit_divisor;
                            div_state_q <= DHit;
                        end else if (div_state_q == DHit) begin
                            hit_res_q   <= sat16(quo_next);
                            quo_q       <= stall_dividend;
                            div_q       <= WindowDiv;
                            div_state_q <= DStall;
                        end else begin
                            stall_res_q <= sat8(quo_next);
                            div_state_q <= DLoad;
                        end
                    end
                end
                DLoad: begin
                    ipc_o             <= ipc_res_q;
                    l1_hit_rate_o     <= hit_res_q;
                    stall_pct_o       <= stall_res_q;
                    ipc_low_o         <= ipc_res_q < 16'(IpcLowLimit);
                    cache_miss_high_o <= hit_res_q < 16'(HitLowLimit);
                    stall_high_o      <= stall_res_q > 8'(PIPELINE_STALL_THRESHOLD);
                    results_valid_o   <= 1'b1;
                    div_state_q       <= DIdle;
                end
                default: div_state_q <= DIdle;
            endcase
        end
    end

    assign busy_o = (div_state_q != DIdle);

endmodule

// File: tb/tb_riscv_perf_window_monitor.sv
// Bench for riscv_perf_window_monitor: per-cycle comparison against a window-level arithmetic
// model, plus literal expectations for the directed windows.
module tb_riscv_perf_window_monitor;

    localparam longint W   = 1024;
    localparam longint P   = 1000;
    localparam longint DW  = 32 + $clog2(1001);
    localparam longint LAT = 3 * DW + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  retire = 2'd0;
    logic        l1_hit = 1'b0;
    logic        l1_miss = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] ipc_o, l1_hit_rate_o;
    logic [7:0]  stall_pct_o;
    logic        results_valid_o, ipc_low_o, cache_miss_high_o, stall_high_o, busy_o;

    riscv_perf_window_monitor dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .enable_i          (enable),
        .clear_i           (clear),
        .retire_cnt_i      (retire),
        .l1_hit_i          (l1_hit),
        .l1_miss_i         (l1_miss),
        .stall_i           (stall),
        .ipc_o             (ipc_o),
        .l1_hit_rate_o     (l1_hit_rate_o),
        .stall_pct_o       (stall_pct_o),
        .results_valid_o   (results_valid_o),
        .ipc_low_o         (ipc_low_o),
        .cache_miss_high_o (cache_miss_high_o),
        .stall_high_o      (stall_high_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
            if (n_checks - n_pass >= 100) begin
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        end
    endtask

    typedef struct {
        longint due;
        longint ipc;
        longint hr;
        longint st;
        bit     il;
        bit     cm;
        bit     sh;
    } res_t;

    typedef struct {
        bit     chk;
        longint ipc;
        longint hr;
        longint st;
        bit     il;
        bit     cm;
        bit     sh;
    } lit_t;

    res_t   exp_q[$];
    lit_t   lit_q[$];
    res_t   held;
    longint now = 0;
    longint last_close = -100000;
    longint win_cnt = 0, m_ret = 0, m_hit = 0, m_miss = 0, m_stall = 0;

    function automatic res_t model_result(input longint ret, input longint hit,
                                          input longint miss, input longint stl,
                                          input longint due);
        res_t r;
        r.due = due;
        r.ipc = ret * P / W;
        if (r.ipc > 65535) r.ipc = 65535;
        r.hr  = (hit + miss == 0) ? P : hit * P / (hit + miss);
        r.st  = stl * 100 / W;
        if (r.st > 255) r.st = 255;
        r.il  = r.ipc < 85 * P / 100;
        r.cm  = (P - r.hr) > 15 * P / 100;
        r.sh  = r.st > 20;
        return r;
    endfunction

    function automatic logic [44:0] pack(input bit v, input bit b, input longint ipc,
                                         input longint hr, input longint st, input bit il,
                                         input bit cm, input bit sh);
        return {v, b, 16'(ipc), 16'(hr), 8'(st), il, cm, sh};
    endfunction

    // Per-cycle model comparison, sampled on the falling edge.
    initial begin
        logic [44:0] act, expv;
        bit          ev, eb;
        forever begin
            @(negedge clk);
            act = {results_valid_o, busy_o, ipc_o, l1_hit_rate_o, stall_pct_o,
                   ipc_low_o, cache_miss_high_o, stall_high_o};
            if (rst) begin
                exp_q.delete();
                held       = '{default: 0};
                last_close = -100000;
                win_cnt = 0; m_ret = 0; m_hit = 0; m_miss = 0; m_stall = 0;
                check("reset outputs", act, 0);
            end else begin
                ev = (exp_q.size() > 0) && (exp_q[0].due == now);
                if (ev) held = exp_q.pop_front();
                eb   = (now > last_close) && (now <= last_close + LAT);
                expv = pack(ev, eb, held.ipc, held.hr, held.st, held.il, held.cm, held.sh);
                check($sformatf("outputs cycle %0d", now), act, expv);
                if (enable && !clear) begin
                    m_ret += retire; m_hit += l1_hit; m_miss += l1_miss; m_stall += stall;
                    win_cnt++;
                    if (win_cnt == W) begin
                        exp_q.push_back(model_result(m_ret, m_hit, m_miss, m_stall,
                                                     now + 1 + LAT));
                        last_close = now;
                        win_cnt = 0; m_ret = 0; m_hit = 0; m_miss = 0; m_stall = 0;
                    end
                end else begin
                    win_cnt = 0; m_ret = 0; m_hit = 0; m_miss = 0; m_stall = 0;
                end
            end
            now++;
        end
    end

    // Literal expectations for directed windows, matched to result pulses in order.
    initial begin
        lit_t l;
        forever begin
            @(negedge clk);
            if (!rst && results_valid_o) begin
                if (lit_q.size() == 0) check("unexpected result pulse", 1, 0);
                else begin
                    l = lit_q.pop_front();
                    if (l.chk) begin
                        check("lit ipc_o", ipc_o, l.ipc);
                        check("lit l1_hit_rate_o", l1_hit_rate_o, l.hr);
                        check("lit stall_pct_o", stall_pct_o, l.st);
                        check("lit ipc_low_o", ipc_low_o, l.il);
                        check("lit cache_miss_high_o", cache_miss_high_o, l.cm);
                        check("lit stall_high_o", stall_high_o, l.sh);
                    end
                end
            end
        end
    end

    task automatic push_lit(input bit chk, input longint ipc, input longint hr, input longint st,
                            input bit il, input bit cm, input bit sh);
        lit_t l;
        l = '{chk, ipc, hr, st, il, cm, sh};
        lit_q.push_back(l);
    endtask

    task automatic drive(input int kind, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            enable = 1'b1; clear = 1'b0; retire = 2'd0;
            l1_hit = 1'b0; l1_miss = 1'b0; stall = 1'b0;
            case (kind)
                0: retire = 2'd1;
                1: retire = 2'd2;
                2: retire = (i % 2 == 0) ? 2'd1 : 2'd0;
                3: begin l1_hit = (i < 900); l1_miss = (i >= 900 && i < 1000); end
                4: begin l1_hit = (i < 800); l1_miss = (i >= 800 && i < 1000); end
                5: stall = (i < 256);
                6: stall = (i < 200);
                7: begin l1_hit = (i < 400); l1_miss = (i < 100); end
                8: begin
                    retire  = 2'($urandom_range(0, 2));
                    l1_hit  = 1'($urandom_range(0, 1));
                    l1_miss = ($urandom_range(0, 3) == 0);
                    stall   = ($urandom_range(0, 2) == 0);
                end
                10: begin enable = 1'b0; retire = 2'd2; l1_hit = 1'b1; stall = 1'b1; end
                11: begin clear = 1'b1; retire = 2'd2; l1_hit = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        @(negedge clk);
        check({tag, " ipc_o"}, ipc_o, 0);
        check({tag, " l1_hit_rate_o"}, l1_hit_rate_o, 0);
        check({tag, " stall_pct_o"}, stall_pct_o, 0);
        check({tag, " results_valid_o"}, results_valid_o, 0);
        check({tag, " flags"}, {ipc_low_o, cache_miss_high_o, stall_high_o}, 0);
        check({tag, " busy_o"}, busy_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        drive(10, 3);
        check_zero_outputs("reset");
        @(posedge clk); #1; rst = 1'b0; enable = 1'b0;

        drive(0, int'(W)); push_lit(1, 1000, 1000, 0, 0, 0, 0);
        drive(1, int'(W)); push_lit(1, 2000, 1000, 0, 0, 0, 0);
        drive(2, int'(W)); push_lit(1, 500, 1000, 0, 1, 0, 0);
        drive(3, int'(W)); push_lit(1, 0, 900, 0, 1, 0, 0);
        drive(4, int'(W)); push_lit(1, 0, 800, 0, 1, 1, 0);
        drive(5, int'(W)); push_lit(1, 0, 1000, 25, 1, 0, 1);
        drive(6, int'(W)); push_lit(1, 0, 1000, 19, 1, 0, 0);
        drive(7, int'(W)); push_lit(1, 0, 800, 0, 1, 1, 0);

        // Partial window aborted by enable drop, then by clear.
        drive(1, 500);
        drive(10, 10);
        drive(0, int'(W)); push_lit(1, 1000, 1000, 0, 0, 0, 0);
        drive(1, 300);
        drive(11, 1);
        drive(0, int'(W)); push_lit(1, 1000, 1000, 0, 0, 0, 0);

        for (int k = 0; k < 3; k++) begin
            drive(8, int'(W));
            push_lit(0, 0, 0, 0, 0, 0, 0);
        end

        // Reset lands while the hit-rate division is running.
        drive(8, int'(W));
        drive(8, 60);
        @(posedge clk); #1; rst = 1'b1; enable = 1'b0;
        check_zero_outputs("reset during divide");
        drive(10, 3);
        @(posedge clk); #1; rst = 1'b0; enable = 1'b0;

        drive(1, int'(W)); push_lit(1, 2000, 1000, 0, 0, 0, 0);
        drive(10, 200);

        check("pending literal results", lit_q.size(), 0);
        check("pending model results", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
